// File: rtl/request_encoder_8_3_pkg.sv
// Shared sizes and encode/decode helpers for the 8-to-3 request encoder
// and the one-hot 3-to-8 select decoders.
package request_encoder_8_3_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] encode_lowest(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] decode_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/request_encoder_8_3_priority.sv
// Combinational find-first-set starting at a given index, wrapping 7 -> 0.
module priority_encoder_8_3
  import request_encoder_8_3_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_cand,
  input  logic [IDX_W-1:0]   i_start,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;

  // Rotate so i_start lands at bit 0, search, then add the offset back.
  always_comb begin
    w_dbl = {i_cand, i_cand} >> i_start;
    w_rot = w_dbl[NUM_REQ-1:0];
    w_off = encode_lowest(w_rot);
    o_any = |i_cand;
    o_idx = i_start + w_off;
  end

endmodule

// File: rtl/request_encoder_8_3.sv
// Sticky request capture with one encoded index presented per valid/ack
// handshake; fixed or rotating priority.
module request_encoder_8_3
  import request_encoder_8_3_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               ack,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [NUM_REQ-1:0] pending,
  output logic               dropped
);

  logic [NUM_REQ-1:0] r_pend;
  logic               r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_last;
  logic               r_dropped;

  logic               w_accept;
  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_next_pend;
  logic [NUM_REQ-1:0] w_cand;
  logic [IDX_W-1:0]   w_start;
  logic               w_load;
  logic               w_any;
  logic [IDX_W-1:0]   w_idx;

  // Set wins over clear: a re-request on the acked line keeps it pending.
  always_comb begin
    w_accept    = r_valid & ack;
    w_clr       = w_accept ? decode_onehot(r_idx) : '0;
    w_next_pend = (r_pend & ~w_clr) | req;
    w_cand      = w_next_pend & mask;
    w_start     = ROUND_ROBIN ? (r_last + IDX_W'(1)) : '0;
    w_load      = enable & (~r_valid | w_accept);
  end

  priority_encoder_8_3 u_prio (
    .i_cand  (w_cand),
    .i_start (w_start),
    .o_any   (w_any),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend    <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_dropped <= 1'b0;
    end else begin
      r_pend    <= w_next_pend;
      r_dropped <= |(req & r_pend & ~w_clr);
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_idx  <= w_idx;
          r_last <= w_idx;
        end
      end else if (w_accept) begin
        // Acked while disabled: withdraw until enable returns.
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign pending   = r_pend;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_request_encoder_8_3.sv
// Directed bench for request_encoder_8_3: fixed-priority and round-robin instances.
module tb_request_encoder_8_3;

  logic       clock;
  logic       reset_n;
  logic       enable, ack;
  logic [7:0] req, mask;
  logic       out_valid, dropped;
  logic [2:0] out_idx;
  logic [7:0] pending;

  logic       rr_enable, rr_ack;
  logic [7:0] rr_req, rr_mask;
  logic       rr_valid, rr_dropped;
  logic [2:0] rr_idx;
  logic [7:0] rr_pending;

  int checks;
  int failures;

  request_encoder_8_3 #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .req       (req),
    .mask      (mask),
    .ack       (ack),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .dropped   (dropped)
  );

  request_encoder_8_3 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (rr_enable),
    .req       (rr_req),
    .mask      (rr_mask),
    .ack       (rr_ack),
    .out_valid (rr_valid),
    .out_idx   (rr_idx),
    .pending   (rr_pending),
    .dropped   (rr_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    enable    = 1'b1;
    ack       = 1'b0;
    req       = 8'h00;
    mask      = 8'hFF;
    rr_enable = 1'b1;
    rr_ack    = 1'b0;
    rr_req    = 8'h00;
    rr_mask   = 8'hFF;

    #2;
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_idx",     32'(out_idx),   32'd0);
    chk("rst_pending", 32'(pending),   32'h00);
    chk("rst_dropped", 32'(dropped),   32'd0);
    #10;
    reset_n = 1'b1;

    // Round-robin with every line requesting and ack every cycle.
    rr_req = 8'hFF;
    rr_ack = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("rr_valid", 32'(rr_valid), 32'd1);
      chk("rr_idx",   32'(rr_idx),   32'((k - 1) % 8));
      chk("rr_drop",  32'(rr_dropped), (k >= 2) ? 32'd1 : 32'd0);
    end
    chk("rr_pending", 32'(rr_pending), 32'hFF);
    rr_req = 8'h00;
    for (int k = 0; k < 10; k++) step();
    chk("rr_drained", 32'(rr_valid), 32'd0);
    rr_ack = 1'b0;

    // One-cycle request on lines 2 and 5; lowest wins and stays put.
    req = 8'h24;
    step();
    req = 8'h00;
    chk("t1_valid",   32'(out_valid), 32'd1);
    chk("t1_idx",     32'(out_idx),   32'd2);
    chk("t1_pending", 32'(pending),   32'h24);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_hold", 32'(out_idx), 32'd2);
    end
    ack = 1'b1;
    step();
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_idx",   32'(out_idx),   32'd5);
    step();
    ack = 1'b0;
    chk("t2_empty_valid",   32'(out_valid), 32'd0);
    chk("t2_empty_pending", 32'(pending),   32'h00);

    // Masked line 0 stays pending while line 3 is served.
    mask = 8'hFE;
    req  = 8'h01;
    step();
    chk("m_masked_valid", 32'(out_valid), 32'd0);
    req = 8'h08;
    step();
    req = 8'h00;
    chk("m_idx",     32'(out_idx), 32'd3);
    chk("m_pending", 32'(pending), 32'h09);
    mask = 8'h00;
    step();
    chk("m_not_withdrawn", 32'(out_valid), 32'd1);
    mask = 8'hFE;
    ack  = 1'b1;
    step();
    ack = 1'b0;
    chk("m_after_ack_valid",   32'(out_valid), 32'd0);
    chk("m_after_ack_pending", 32'(pending),   32'h01);
    mask = 8'hFF;
    step();
    chk("m_unmask_valid", 32'(out_valid), 32'd1);
    chk("m_unmask_idx",   32'(out_idx),   32'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("m_clear", 32'(pending), 32'h00);

    // Disabled: capture continues but nothing is presented.
    enable = 1'b0;
    req    = 8'h10;
    step();
    req = 8'h00;
    step();
    chk("en_off_valid",   32'(out_valid), 32'd0);
    chk("en_off_pending", 32'(pending),   32'h10);
    enable = 1'b1;
    step();
    chk("en_on_valid", 32'(out_valid), 32'd1);
    chk("en_on_idx",   32'(out_idx),   32'd4);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("en_clear_valid", 32'(out_valid), 32'd0);

    // Ack while disabled withdraws the presentation until enable returns.
    req = 8'h30;
    step();
    req = 8'h00;
    chk("dis_idx", 32'(out_idx), 32'd4);
    enable = 1'b0;
    ack    = 1'b1;
    step();
    ack = 1'b0;
    chk("dis_ack_valid",   32'(out_valid), 32'd0);
    chk("dis_ack_pending", 32'(pending),   32'h20);
    step();
    chk("dis_hold_valid", 32'(out_valid), 32'd0);
    enable = 1'b1;
    step();
    chk("dis_resume_idx",   32'(out_idx),   32'd5);
    chk("dis_resume_valid", 32'(out_valid), 32'd1);

    // Re-request on the acked line: set beats clear, then dropped pulses.
    req = 8'h20;
    ack = 1'b1;
    step();
    req = 8'h00;
    ack = 1'b0;
    chk("rereq_pending", 32'(pending),   32'h20);
    chk("rereq_valid",   32'(out_valid), 32'd1);
    chk("rereq_idx",     32'(out_idx),   32'd5);
    chk("rereq_nodrop",  32'(dropped),   32'd0);
    req = 8'h20;
    step();
    req = 8'h00;
    chk("collide_drop", 32'(dropped), 32'd1);
    step();
    chk("collide_pulse_end", 32'(dropped), 32'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("rereq_clear", 32'(pending), 32'h00);

    // Asynchronous reset while index 6 is presented.
    req = 8'h40;
    step();
    req = 8'h00;
    chk("ar_idx", 32'(out_idx), 32'd6);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid",   32'(out_valid), 32'd0);
    chk("ar_idx0",    32'(out_idx),   32'd0);
    chk("ar_pending", 32'(pending),   32'h00);
    #2;
    reset_n = 1'b1;
    step();
    step();
    chk("ar_idle", 32'(out_valid), 32'd0);
    req = 8'h02;
    step();
    req = 8'h00;
    chk("ar_new_valid", 32'(out_valid), 32'd1);
    chk("ar_new_idx",   32'(out_idx),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
